pdm_fader: RTL and testbench



---
 rtl/pdm_fader.sv | 105 ++++++++++
 tb/tb_pdm_fader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_fader.sv
// pdm_fader: CH first-order PDM LED outputs whose levels ramp linearly toward host-written targets.
// Latency: writes show on fading the next cycle and levels move only on prescaler ticks; there is no backpressure, so writes are always accepted.
module pdm_fader #(
    parameter int N  = 16,
    parameter int CH = 4,
    parameter int AW = 2,
    parameter int PW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_target,
    input  logic [N-1:0]  wr_step,
    input  logic [PW-1:0] rate,
    input  logic [AW-1:0] rd_addr,
    output logic [N-1:0]  rd_level,
    output logic [CH-1:0] fading,
    output logic [CH-1:0] O
);

    logic [PW-1:0]        cnt_q;
    logic [PW-1:0]        cnt_d;
    logic                 tick;
    logic [CH-1:0][N-1:0] cur_all;

    // A counter above a freshly lowered rate still ticks at once.
    always_comb begin
        tick  = (cnt_q >= rate);
        cnt_d = tick ? '0 : cnt_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        for (genvar g = 0; g < CH; g++) begin : g_ch
            logic [N-1:0] cur_q;
            logic [N-1:0] cur_d;
            logic [N-1:0] tgt_q;
            logic [N-1:0] step_q;
            logic [N+1:0] sigma_q;
            logic [N+1:0] sigma_d;
            logic [N:0]   sum_w;
            logic [N:0]   diff_w;
            logic         wr_hit;

            assign wr_hit = wr_en && (int'(wr_addr) == g);
            assign sum_w  = {1'b0, cur_q} + {1'b0, step_q};
            assign diff_w = {1'b0, cur_q} - {1'b0, step_q};

            // The extra bit in sum/diff makes overshoot and underflow visible, so both clamp to target.
            always_comb begin
                cur_d = cur_q;
                if (tick && (cur_q != tgt_q)) begin
                    if (step_q == '0) begin
                        cur_d = tgt_q;
                    end else if (cur_q < tgt_q) begin
                        cur_d = (sum_w >= {1'b0, tgt_q}) ? tgt_q : sum_w[N-1:0];
                    end else begin
                        cur_d = (diff_w[N] || (diff_w[N-1:0] <= tgt_q)) ? tgt_q : diff_w[N-1:0];
                    end
                end
            end

            // Feedback {O,O,cur} subtracts full scale whenever the output is high.
            assign sigma_d = sigma_q + {O[g], O[g], cur_q};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cur_q   <= '0;
                    tgt_q   <= '0;
                    step_q  <= '0;
                    sigma_q <= '1;
                end else begin
                    cur_q   <= cur_d;
                    sigma_q <= sigma_d;
                    if (wr_hit) begin
                        tgt_q  <= wr_target;
                        step_q <= wr_step;
                    end
                end
            end

            assign O[g]       = ~sigma_q[N+1];
            assign fading[g]  = (cur_q != tgt_q);
            assign cur_all[g] = cur_q;
        end
    endgenerate

    always_comb begin
        rd_level = '0;
        for (int i = 0; i < CH; i++) begin
            if (int'(rd_addr) == i) begin
                rd_level = cur_all[i];
            end
        end
    end

endmodule

// File: tb/tb_pdm_fader.sv
// tb_pdm_fader: two pdm_fader instances (default sizing, and N=4/CH=2/AW=3) checked every cycle
// against an integer model of density accumulation and linear fading, plus directed literal expectations.
module tb_pdm_fader;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Instance A: N=16 CH=4 AW=2 PW=12
    logic        a_we;
    logic [1:0]  a_wa;
    logic [15:0] a_wt, a_ws;
    logic [11:0] a_rate;
    logic [1:0]  a_ra;
    logic [15:0] a_lvl;
    logic [3:0]  a_fad, a_o;

    // Instance B: N=4 CH=2 AW=3 PW=4
    logic        b_we;
    logic [2:0]  b_wa;
    logic [3:0]  b_wt, b_ws;
    logic [3:0]  b_rate;
    logic [2:0]  b_ra;
    logic [3:0]  b_lvl;
    logic [1:0]  b_fad, b_o;

    pdm_fader #(.N(16), .CH(4), .AW(2), .PW(12)) u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(a_we), .wr_addr(a_wa), .wr_target(a_wt),
        .wr_step(a_ws), .rate(a_rate), .rd_addr(a_ra), .rd_level(a_lvl),
        .fading(a_fad), .O(a_o)
    );

    pdm_fader #(.N(4), .CH(2), .AW(3), .PW(4)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en(b_we), .wr_addr(b_wa), .wr_target(b_wt),
        .wr_step(b_ws), .rate(b_rate), .rd_addr(b_ra), .rd_level(b_lvl),
        .fading(b_fad), .O(b_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: acc is the signed density error; output is high while it is non-negative.
    int m_n[2]  = '{16, 4};
    int m_ch[2] = '{4, 2};
    int m_cur[2][4];
    int m_tgt[2][4];
    int m_stp[2][4];
    int m_acc[2][4];
    int m_cnt[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0;
            for (int i = 0; i < 4; i++) begin
                m_cur[d][i] = 0;
                m_tgt[d][i] = 0;
                m_stp[d][i] = 0;
                m_acc[d][i] = -1;
            end
        end
    endtask

    task automatic model_step(input int d, input bit we, input int wa, input int wt,
                              input int ws, input int rt);
        bit tick;
        int full;
        int nxt;
        tick = (m_cnt[d] >= rt);
        full = 1 << m_n[d];
        for (int i = 0; i < m_ch[d]; i++) begin
            if (m_acc[d][i] >= 0) m_acc[d][i] = m_acc[d][i] + m_cur[d][i] - full;
            else                  m_acc[d][i] = m_acc[d][i] + m_cur[d][i];
            if (tick) begin
                nxt = m_cur[d][i];
                if (m_stp[d][i] == 0) begin
                    nxt = m_tgt[d][i];
                end else if (m_cur[d][i] < m_tgt[d][i]) begin
                    nxt = m_cur[d][i] + m_stp[d][i];
                    if (nxt > m_tgt[d][i]) nxt = m_tgt[d][i];
                end else if (m_cur[d][i] > m_tgt[d][i]) begin
                    nxt = m_cur[d][i] - m_stp[d][i];
                    if (nxt < m_tgt[d][i]) nxt = m_tgt[d][i];
                end
                m_cur[d][i] = nxt;
            end
        end
        if (we && wa < m_ch[d]) begin
            m_tgt[d][wa] = wt;
            m_stp[d][wa] = ws;
        end
        m_cnt[d] = tick ? 0 : m_cnt[d] + 1;
    endtask

    function automatic logic [31:0] m_o(input int d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < m_ch[d]; i++) r[i] = (m_acc[d][i] >= 0);
        return r;
    endfunction

    function automatic logic [31:0] m_fad(input int d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < m_ch[d]; i++) r[i] = (m_cur[d][i] != m_tgt[d][i]);
        return r;
    endfunction

    function automatic logic [31:0] m_lvl(input int d, input int ra);
        if (ra < m_ch[d]) return 32'(m_cur[d][ra]);
        return 32'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(0, a_we, int'(a_wa), int'(a_wt), int'(a_ws), int'(a_rate));
            model_step(1, b_we, int'(b_wa), int'(b_wt), int'(b_ws), int'(b_rate));
        end
    end

    always @(negedge clk) begin
        chk("a_O",        32'(a_o),   m_o(0));
        chk("a_fading",   32'(a_fad), m_fad(0));
        chk("a_rd_level", 32'(a_lvl), m_lvl(0, int'(a_ra)));
        chk("b_O",        32'(b_o),   m_o(1));
        chk("b_fading",   32'(b_fad), m_fad(1));
        chk("b_rd_level", 32'(b_lvl), m_lvl(1, int'(b_ra)));
    end

    task automatic a_write(input int ch, input int tg, input int st);
        @(posedge clk);
        #1;
        a_we = 1'b1; a_wa = 2'(ch); a_wt = 16'(tg); a_ws = 16'(st);
        @(posedge clk);
        #1;
        a_we = 1'b0;
    endtask

    task automatic b_write(input int ch, input int tg, input int st);
        @(posedge clk);
        #1;
        b_we = 1'b1; b_wa = 3'(ch); b_wt = 4'(tg); b_ws = 4'(st);
        @(posedge clk);
        #1;
        b_we = 1'b0;
    endtask

    // Waits (bounded) for a_lvl to differ from old; n = negedges waited, 0 on timeout.
    task automatic wait_a_change(input logic [15:0] old, output int n);
        n = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (a_lvl !== old) begin
                n = c;
                break;
            end
        end
        chk("wait_level_change", 32'(n != 0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        logic [7:0]  acc_o;
        logic [7:0]  acc_f;
        int          n;
        int          t0, t1, w0, w1;
        logic [15:0] prev;

        a_we = 0; a_wa = 0; a_wt = 0; a_ws = 0; a_rate = 0; a_ra = 0;
        b_we = 0; b_wa = 0; b_wt = 0; b_ws = 0; b_rate = 0; b_ra = 0;

        #1 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;

        // Idle after reset: everything dark and settled.
        acc_o = '0; acc_f = '0;
        repeat (1000) begin
            @(negedge clk);
            acc_o |= {2'b0, b_o, a_o};
            acc_f |= {2'b0, b_fad, a_fad};
        end
        chk("idle_O", 32'(acc_o), 32'd0);
        chk("idle_fading", 32'(acc_f), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1 a_ra = 2'(k); #1 chk("idle_a_level", 32'(a_lvl), 32'd0);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1 b_ra = 3'(k); #1 chk("idle_b_level", 32'(b_lvl), 32'd0);
        end

        // Duty on B with rate=0 and jump writes.
        b_write(0, 8, 0);
        b_write(1, 3, 0);
        @(posedge clk);
        t0 = 0; t1 = 0; w0 = 0; w1 = 0;
        for (int c = 1; c <= 160; c++) begin
            @(negedge clk);
            w0 += int'(b_o[0]);
            w1 += int'(b_o[1]);
            if (c % 16 == 0) begin
                chk("duty_window_ch0", 32'(w0 >= 7 && w0 <= 9), 32'd1);
                chk("duty_window_ch1", 32'(w1 >= 2 && w1 <= 4), 32'd1);
                t0 += w0; t1 += w1; w0 = 0; w1 = 0;
            end
        end
        chk("duty_total_ch0", 32'(t0), 32'd80);
        chk("duty_total_ch1", 32'(t1), 32'd30);

        // Out-of-range write address changes nothing.
        b_write(5, 15, 1);
        repeat (8) @(negedge clk);
        #1 b_ra = 3'd0; #1 chk("oor_b_level0", 32'(b_lvl), 32'd8);
        #1 b_ra = 3'd1; #1 chk("oor_b_level1", 32'(b_lvl), 32'd3);
        #1 b_ra = 3'd5; #1 chk("oor_b_level5", 32'(b_lvl), 32'd0);
        chk("oor_b_fading", 32'(b_fad), 32'd0);

        // Fade ramp on A ch2, rate=3.
        @(posedge clk);
        #1 a_rate = 12'd3; a_ra = 2'd2;
        a_write(2, 16'h1000, 16'h0400);
        @(negedge clk);
        chk("ramp_fading_on", 32'(a_fad[2]), 32'd1);
        chk("ramp_start_level", 32'(a_lvl), 32'd0);
        prev = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            wait_a_change(prev, n);
            chk("ramp_level", 32'(a_lvl), 32'(16'h0400 * (k + 1)));
            if (k > 0) chk("ramp_spacing", 32'(n), 32'd4);
            chk("ramp_fading", 32'(a_fad[2]), (k < 3) ? 32'd1 : 32'd0);
            prev = a_lvl;
        end

        // Clamp down, then clamp up without wrapping.
        a_write(2, 16'h0F00, 16'h0400);
        wait_a_change(16'h1000, n);
        chk("clamp_down", 32'(a_lvl), 32'h0F00);
        chk("clamp_down_fading", 32'(a_fad[2]), 32'd0);
        a_write(2, 16'hFFFF, 16'h8000);
        wait_a_change(16'h0F00, n);
        chk("clamp_up1", 32'(a_lvl), 32'h8F00);
        wait_a_change(16'h8F00, n);
        chk("clamp_up2", 32'(a_lvl), 32'hFFFF);
        repeat (12) @(negedge clk);
        chk("clamp_hold", 32'(a_lvl), 32'hFFFF);
        chk("clamp_fading", 32'(a_fad[2]), 32'd0);

        // Write landing on a tick: that tick still uses the old target.
        #1 a_ra = 2'd0;
        a_write(0, 16'h0800, 16'h0100);
        wait_a_change(16'h0000, n);
        chk("coinc_first_step", 32'(a_lvl), 32'h0100);
        repeat (2) @(posedge clk);
        a_write(0, 16'h0000, 16'h0100);
        @(negedge clk);
        chk("coinc_old_target", 32'(a_lvl), 32'h0200);
        chk("coinc_fading", 32'(a_fad[0]), 32'd1);
        wait_a_change(16'h0200, n);
        chk("coinc_new_target", 32'(a_lvl), 32'h0100);
        chk("coinc_spacing", 32'(n), 32'd4);
        wait_a_change(16'h0100, n);
        chk("coinc_reached", 32'(a_lvl), 32'h0000);
        chk("coinc_done_fading", 32'(a_fad[0]), 32'd0);

        // Asynchronous reset in the middle of a ramp.
        @(posedge clk);
        #1 a_rate = 12'd0; a_ra = 2'd1; b_ra = 3'd0;
        a_write(1, 16'hFFFF, 16'h0100);
        repeat (20) @(negedge clk);
        chk("pre_reset_fading", 32'(a_fad[1]), 32'd1);
        chk("pre_reset_b_level", 32'(b_lvl), 32'd8);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_a_O", 32'(a_o), 32'd0);
        chk("arst_a_fading", 32'(a_fad), 32'd0);
        chk("arst_a_level", 32'(a_lvl), 32'd0);
        chk("arst_b_O", 32'(b_o), 32'd0);
        chk("arst_b_fading", 32'(b_fad), 32'd0);
        chk("arst_b_level", 32'(b_lvl), 32'd0);
        #20 rst_n = 1'b1;
        acc_o = '0; acc_f = '0;
        repeat (200) begin
            @(negedge clk);
            acc_o |= {2'b0, b_o, a_o};
            acc_f |= {2'b0, b_fad, a_fad};
        end
        chk("post_reset_O", 32'(acc_o), 32'd0);
        chk("post_reset_fading", 32'(acc_f), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1 a_ra = 2'(k); #1 chk("post_reset_a_level", 32'(a_lvl), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
